// File: rtl/sprite_addr_gen.sv
// Sprite address generator: tracks the raster position of a streamed pixel
// scan, tests each pixel against one sprite rectangle and emits the sprite
// ROM address. Two register stages: hit test / local offset, then bank base.
// Sprite attributes are shadowed at frame_start so a frame never tears.
module sprite_addr_gen #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int XW           = 10,
    parameter int YW           = 9,
    parameter int SPR_W        = 30,
    parameter int SPR_H        = 30,
    parameter int N_ORIENT     = 4,
    parameter int N_COLOR      = 4,
    parameter int CRASH_ORIENT = 5,
    parameter int ADDR_W       = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic              spr_en,
    input  logic [XW-1:0]     spr_x,
    input  logic [YW-1:0]     spr_y,
    input  logic [2:0]        spr_orient,
    input  logic [2:0]        spr_color,
    output logic              out_valid,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic              in_sprite,
    output logic [ADDR_W-1:0] mem_addr
);

    localparam int FR = SPR_W * SPR_H;
    localparam logic [ADDR_W-1:0] FR_A       = ADDR_W'(FR);
    localparam logic [ADDR_W-1:0] BANK_A     = ADDR_W'(N_ORIENT * FR);
    localparam logic [ADDR_W-1:0] CRASH_BASE = ADDR_W'(N_ORIENT * N_COLOR * FR);
    localparam logic [ADDR_W-1:0] SPR_W_A    = ADDR_W'(SPR_W);

    // raster position and per-frame shadow attributes
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          en_q;
    logic [XW-1:0] sx_q;
    logic [YW-1:0] sy_q;
    logic [2:0]    so_q, sc_q;

    // a pixel is only taken when no frame restart competes for the same cycle
    logic accept;
    assign accept = pix_valid & ~frame_start;

    // stage valid bits: [1] = hit-test stage, [2] = output stage
    logic [2:1] vld_q;

    // stage 1 registers
    logic [XW-1:0]     s1_x_q;
    logic [YW-1:0]     s1_y_q;
    logic              s1_hit_q;
    logic              s1_crash_q;
    logic [2:0]        s1_orient_q, s1_color_q;
    logic [ADDR_W-1:0] s1_off_q;

    // stage 2 (output) registers
    logic [XW-1:0]     out_x_q;
    logic [YW-1:0]     out_y_q;
    logic              in_sprite_q;
    logic [ADDR_W-1:0] mem_addr_q;

    // raster next-state: restart on frame_start, else step with line/frame wrap
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (frame_start) begin
            cx_d = '0;
            cy_d = '0;
        end else if (pix_valid) begin
            if (cx_q == XW'(SCREEN_W - 1)) begin
                cx_d = '0;
                cy_d = (cy_q == YW'(SCREEN_H - 1)) ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
    end

    // hit test: bounds compared one bit wider so x+SPR_W cannot wrap
    logic [XW:0]       cx_w, x_lo, x_hi;
    logic [YW:0]       cy_w, y_lo, y_hi;
    logic              legal, crash_d, hit_d;
    logic [XW-1:0]     col;
    logic [YW-1:0]     row;
    logic [ADDR_W-1:0] off_d;

    // combinational hit flag and in-sprite offset for the current raster pixel
    always_comb begin
        cx_w    = {1'b0, cx_q};
        x_lo    = {1'b0, sx_q};
        x_hi    = x_lo + (XW+1)'(SPR_W);
        cy_w    = {1'b0, cy_q};
        y_lo    = {1'b0, sy_q};
        y_hi    = y_lo + (YW+1)'(SPR_H);
        crash_d = (int'(so_q) == CRASH_ORIENT);
        legal   = ((int'(so_q) < N_ORIENT) && (int'(sc_q) < N_COLOR)) || crash_d;
        hit_d   = en_q && legal && (cx_w >= x_lo) && (cx_w < x_hi)
                               && (cy_w >= y_lo) && (cy_w < y_hi);
        col     = cx_q - sx_q;
        row     = cy_q - sy_q;
        off_d   = hit_d ? (ADDR_W'(row) * SPR_W_A + ADDR_W'(col)) : '0;
    end

    // bank base: crash bank sits after all orientation/colour banks
    logic [ADDR_W-1:0] base_d, addr_d;

    // stage 2 address: bank base plus the offset from stage 1
    always_comb begin
        base_d = s1_crash_q ? CRASH_BASE
                            : ADDR_W'(s1_orient_q) * FR_A + ADDR_W'(s1_color_q) * BANK_A;
        addr_d = s1_hit_q ? (base_d + s1_off_q) : '0;
    end

    // raster counters and shadow attribute latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
            en_q <= 1'b0;
            sx_q <= '0;
            sy_q <= '0;
            so_q <= '0;
            sc_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            if (frame_start) begin
                en_q <= spr_en;
                sx_q <= spr_x;
                sy_q <= spr_y;
                so_q <= spr_orient;
                sc_q <= spr_color;
            end
        end
    end

    // stage 1: capture coordinates, hit flag, offset and the pixel's own attributes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q[1]    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_hit_q    <= 1'b0;
            s1_crash_q  <= 1'b0;
            s1_orient_q <= '0;
            s1_color_q  <= '0;
            s1_off_q    <= '0;
        end else begin
            vld_q[1] <= accept;
            if (accept) begin
                s1_x_q      <= cx_q;
                s1_y_q      <= cy_q;
                s1_hit_q    <= hit_d;
                s1_crash_q  <= crash_d;
                s1_orient_q <= so_q;
                s1_color_q  <= sc_q;
                s1_off_q    <= off_d;
            end
        end
    end

    // stage 2: registered outputs, held while no pixel is reported
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q[2]    <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            in_sprite_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            vld_q[2] <= vld_q[1];
            if (vld_q[1]) begin
                out_x_q     <= s1_x_q;
                out_y_q     <= s1_y_q;
                in_sprite_q <= s1_hit_q;
                mem_addr_q  <= addr_d;
            end
        end
    end

    assign out_valid = vld_q[2];
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign in_sprite = in_sprite_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Bench for sprite_addr_gen: two instances (full 640x480 screen and a small
// 64x40 screen) share all inputs. A raster/rectangle reference model predicts
// every cycle's outputs; table vectors and hand sequences pin specific pixels.
module tb_sprite_addr_gen;

    localparam int SW0 = 640, SH0 = 480;
    localparam int SW1 = 64,  SH1 = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs = 1'b0, pv = 1'b0, en_i = 1'b0;
    logic [9:0] x_i = '0;
    logic [8:0] y_i = '0;
    logic [2:0] o_i = '0, c_i = '0;

    logic        ov  [2];
    logic [9:0]  ox  [2];
    logic [8:0]  oy  [2];
    logic        ins [2];
    logic [18:0] oa  [2];

    always #5 clk = ~clk;

    sprite_addr_gen u0 (
        .clock(clk), .reset(rst), .frame_start(fs), .pix_valid(pv),
        .spr_en(en_i), .spr_x(x_i), .spr_y(y_i), .spr_orient(o_i), .spr_color(c_i),
        .out_valid(ov[0]), .out_x(ox[0]), .out_y(oy[0]), .in_sprite(ins[0]), .mem_addr(oa[0])
    );

    sprite_addr_gen #(.SCREEN_W(SW1), .SCREEN_H(SH1)) u1 (
        .clock(clk), .reset(rst), .frame_start(fs), .pix_valid(pv),
        .spr_en(en_i), .spr_x(x_i), .spr_y(y_i), .spr_orient(o_i), .spr_color(c_i),
        .out_valid(ov[1]), .out_x(ox[1]), .out_y(oy[1]), .in_sprite(ins[1]), .mem_addr(oa[1])
    );

    typedef struct { bit v; int x; int y; int hit; int addr; } res_t;
    typedef struct { int inst; bit en; int x; int y; int o; int c;
                     int px; int py; int e_in; int e_addr; } vec_t;

    res_t pend [2];
    res_t held [2];
    int   mcx [2], mcy [2];
    bit   m_en;
    int   m_x, m_y, m_o, m_c;
    int   n_cmp = 0, n_bad = 0;

    // directed capture of one reported pixel
    bit cap_on = 0, cap_seen = 0;
    int cap_inst, cap_x, cap_y, cap_in, cap_addr;
    // sparse-scan coordinate succession on instance 0
    bit sp_on = 0, sp_have = 0, sp_cross = 0;
    int sp_lx, sp_ly;

    function automatic res_t zero_res();
        res_t r;
        r.v = 0; r.x = 0; r.y = 0; r.hit = 0; r.addr = 0;
        return r;
    endfunction

    function automatic int scr_w(input int i);
        return (i == 0) ? SW0 : SW1;
    endfunction

    function automatic int scr_h(input int i);
        return (i == 0) ? SH0 : SH1;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcx[i] = 0; mcy[i] = 0;
            pend[i] = zero_res(); held[i] = zero_res();
        end
        m_en = 0; m_x = 0; m_y = 0; m_o = 0; m_c = 0;
    endtask

    // result of the current cycle's input on instance i, then advance its raster
    task automatic eval_px(input int i, output res_t r);
        bit legal;
        r = zero_res();
        if (rst || fs || !pv) return;
        r.v = 1; r.x = mcx[i]; r.y = mcy[i];
        legal = (m_o < 4 && m_c < 4) || m_o == 5;
        if (m_en && legal && r.x >= m_x && r.x < m_x + 30 && r.y >= m_y && r.y < m_y + 30) begin
            r.hit  = 1;
            r.addr = ((m_o == 5) ? 16 * 900 : m_o * 900 + m_c * 4 * 900)
                     + (r.y - m_y) * 30 + (r.x - m_x);
            r.addr = r.addr & ((1 << 19) - 1);
        end
        mcx[i]++;
        if (mcx[i] == scr_w(i)) begin
            mcx[i] = 0;
            mcy[i]++;
            if (mcy[i] == scr_h(i)) mcy[i] = 0;
        end
    endtask

    // one clock: predict, advance, compare both instances against the model
    task automatic step();
        res_t r [2];
        int nx, ny;
        for (int i = 0; i < 2; i++) eval_px(i, r[i]);
        if (rst) model_reset();
        else if (fs) begin
            m_en = en_i; m_x = int'(x_i); m_y = int'(y_i); m_o = int'(o_i); m_c = int'(c_i);
            mcx[0] = 0; mcy[0] = 0; mcx[1] = 0; mcy[1] = 0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin pend[i] = zero_res(); held[i] = zero_res(); end
            chk($sformatf("u%0d.out_valid", i), int'(ov[i]), int'(pend[i].v));
            if (pend[i].v) held[i] = pend[i];
            chk($sformatf("u%0d.out_x", i),     int'(ox[i]),  held[i].x);
            chk($sformatf("u%0d.out_y", i),     int'(oy[i]),  held[i].y);
            chk($sformatf("u%0d.in_sprite", i), int'(ins[i]), held[i].hit);
            chk($sformatf("u%0d.mem_addr", i),  int'(oa[i]),  held[i].addr);
            if (cap_on && cap_inst == i && ov[i] && int'(ox[i]) == cap_x && int'(oy[i]) == cap_y) begin
                cap_seen = 1; cap_in = int'(ins[i]); cap_addr = int'(oa[i]);
            end
            pend[i] = rst ? zero_res() : r[i];
        end
        if (sp_on && ov[0]) begin
            if (sp_have) begin
                nx = sp_lx + 1; ny = sp_ly;
                if (nx == SW0) begin nx = 0; ny = sp_ly + 1; end
                chk("sparse_next_x", int'(ox[0]), nx);
                chk("sparse_next_y", int'(oy[0]), ny);
                if (sp_lx == SW0 - 1 && sp_ly == 0) sp_cross = 1;
            end
            sp_have = 1; sp_lx = int'(ox[0]); sp_ly = int'(oy[0]);
        end
    endtask

    task automatic start_frame(input bit en, input int ax, input int ay, input int ao, input int ac);
        en_i = en; x_i = 10'(ax); y_i = 9'(ay); o_i = 3'(ao); c_i = 3'(ac);
        fs = 1; pv = 0;
        step();
        fs = 0;
    endtask

    // stream pixels on instance inst up to (px,py) and check what it reports there
    task automatic scan_to(input int inst, input int px, input int py, input bit restart,
                           input bit en, input int ax, input int ay, input int ao, input int ac,
                           input int e_in, input int e_addr, input string nm);
        int n;
        if (restart) start_frame(en, ax, ay, ao, ac);
        cap_inst = inst; cap_x = px; cap_y = py; cap_seen = 0; cap_on = 1;
        n = 0;
        pv = 1;
        while (!(mcx[inst] == px && mcy[inst] == py) && n < 40000) begin
            step();
            n++;
        end
        step();
        pv = 0;
        step();
        step();
        cap_on = 0;
        chk({nm, ".seen"}, int'(cap_seen), 1);
        chk({nm, ".in_sprite"}, cap_in, e_in);
        chk({nm, ".mem_addr"}, cap_addr, e_addr);
    endtask

    vec_t tbl [9];

    initial begin
        bit rs;
        int pos, tpos;

        tbl[0] = '{0, 1, 100, 2, 2, 1, 100,  2, 1, 5400};
        tbl[1] = '{0, 1, 100, 2, 2, 1, 130,  2, 0, 0};
        tbl[2] = '{0, 1, 100, 2, 2, 1, 129, 31, 1, 6299};
        tbl[3] = '{0, 1, 100, 2, 2, 1, 100, 32, 0, 0};
        tbl[4] = '{0, 1, 100, 0, 5, 3, 105,  2, 1, 14465};
        tbl[5] = '{0, 1, 100, 0, 4, 0, 105,  2, 0, 0};
        tbl[6] = '{0, 1, 100, 0, 1, 4, 105,  2, 0, 0};
        tbl[7] = '{0, 0, 100, 0, 0, 0, 105,  2, 0, 0};
        tbl[8] = '{1, 1,  10, 5, 3, 2,  12,  7, 1, 9962};

        model_reset();
        // reset state
        step();
        step();
        rst = 0;
        step();

        // table vectors; restart the frame only when attributes change or the target is behind
        for (int k = 0; k < 9; k++) begin
            pos  = mcy[tbl[k].inst] * scr_w(tbl[k].inst) + mcx[tbl[k].inst];
            tpos = tbl[k].py * scr_w(tbl[k].inst) + tbl[k].px;
            rs = (k == 0) || tbl[k].en != tbl[k-1].en || tbl[k].x != tbl[k-1].x
                 || tbl[k].y != tbl[k-1].y || tbl[k].o != tbl[k-1].o || tbl[k].c != tbl[k-1].c
                 || tbl[k].inst != tbl[k-1].inst || tpos < pos;
            scan_to(tbl[k].inst, tbl[k].px, tbl[k].py, rs, tbl[k].en, tbl[k].x, tbl[k].y,
                    tbl[k].o, tbl[k].c, tbl[k].e_in, tbl[k].e_addr, $sformatf("vec%0d", k));
        end

        // clipped sprite at the bottom-right corner of the small screen, then frame wrap
        scan_to(1, 63, 39, 1, 1, 44, 30, 0, 0, 1, 289, "clip_corner");
        pv = 1; step(); pv = 0; step();
        chk("wrap_valid", int'(ov[1]), 1);
        chk("wrap_x", int'(ox[1]), 0);
        chk("wrap_y", int'(oy[1]), 0);
        chk("wrap_in_sprite", int'(ins[1]), 0);
        scan_to(1, 44, 30, 0, 1, 44, 30, 0, 0, 1, 0, "next_frame_origin");

        // attribute inputs changed mid-frame are ignored until the next frame_start
        scan_to(0, 100, 0, 1, 1, 100, 0, 0, 0, 1, 0, "old_rect_hit");
        x_i = 10'd200;
        scan_to(0, 200, 0, 0, 1, 200, 0, 0, 0, 0, 0, "old_rect_miss");
        scan_to(0, 200, 0, 1, 1, 200, 0, 0, 0, 1, 0, "new_rect_hit");
        // frame_start with pix_valid in the same cycle drops that pixel
        fs = 1; pv = 1; step();
        fs = 0; pv = 0; step();
        chk("fs_pv_dropped", int'(ov[0]), 0);
        step();
        chk("fs_pv_dropped_late", int'(ov[0]), 0);
        pv = 1; step(); pv = 0; step();
        chk("after_fs_x", int'(ox[0]), 0);
        chk("after_fs_y", int'(oy[0]), 0);

        // sparse pixels across the 639 -> 0 line end
        start_frame(1, 630, 0, 1, 2);
        sp_on = 1; sp_have = 0; sp_cross = 0;
        for (int k = 0; k < 3000 && !(mcy[0] == 1 && mcx[0] >= 6); k++) begin
            pv = (k % 3 == 0);
            step();
        end
        pv = 0; step(); step();
        sp_on = 0;
        chk("sparse_line_cross", int'(sp_cross), 1);

        // reset with the pipeline full
        start_frame(1, 0, 0, 0, 0);
        pv = 1; step(); step(); step();
        chk("pre_reset_valid", int'(ov[0]), 1);
        rst = 1; #1;
        chk("reset_async_u0", int'(ov[0]), 0);
        chk("reset_async_u1", int'(ov[1]), 0);
        model_reset();
        step(); step();
        rst = 0; pv = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_reset_idle", int'(ov[0]), 0);
        end
        scan_to(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset_en0");
        scan_to(0, 3, 0, 1, 1, 0, 0, 0, 0, 1, 3, "reset_en1");

        // randomized traffic against the model
        start_frame(1, 20, 2, 1, 1);
        for (int k = 0; k < 4000; k++) begin
            en_i = ($urandom_range(0, 7) != 0);
            x_i  = 10'($urandom_range(0, 70));
            y_i  = 9'($urandom_range(0, 40));
            o_i  = 3'($urandom_range(0, 7));
            c_i  = 3'($urandom_range(0, 4));
            fs   = ($urandom_range(0, 299) == 0);
            pv   = ($urandom_range(0, 9) < 7);
            step();
        end
        fs = 0; pv = 0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
